// File: rtl/spi_rx_stream.sv
// spi_rx_stream: oversampled serial word receiver feeding a FWFT FIFO with an AXI-Stream master
module spi_rx_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic                                 sclk,
  input  logic                                 sdata,
  input  logic                                 svalid,
  output logic [DATA_WIDTH-1:0]                m_tdata,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
  output logic                                 overflow,
  output logic                                 frame_err,
  output logic [7:0]                           drop_count,
  input  logic                                 clear_flags
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sclk_q, sdata_q, svalid_q;
  logic                   ss_sclk_d_q;
  logic                   ss_sclk, ss_sdata, ss_svalid;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d, word_next;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic [7:0]             drop_q, drop_d;
  logic                   sample, frame_bad, push, pop, accept, drop;

  assign ss_sclk    = sclk_q[SYNC_STAGES-1];
  assign ss_sdata   = sdata_q[SYNC_STAGES-1];
  assign ss_svalid  = svalid_q[SYNC_STAGES-1];
  assign m_tvalid   = level_q != '0;
  assign m_tdata    = mem_q[rd_q];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
  assign drop_count = drop_q;

  // bring the serial link into the aclk domain and keep the previous sclk for edge detection
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sclk_q      <= '0;
      sdata_q     <= '0;
      svalid_q    <= '0;
      ss_sclk_d_q <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sdata_q     <= {sdata_q[SYNC_STAGES-2:0], sdata};
      svalid_q    <= {svalid_q[SYNC_STAGES-2:0], svalid};
      ss_sclk_d_q <= ss_sclk;
    end
  end

  // word assembly, FIFO bookkeeping and sticky error flags
  always_comb begin
    sample     = ss_sclk && !ss_sclk_d_q && ss_svalid;
    frame_bad  = !ss_svalid && cnt_q != '0;
    word_next  = (MSB_FIRST != 0) ? {shift_q[DATA_WIDTH-2:0], ss_sdata} : {ss_sdata, shift_q[DATA_WIDTH-1:1]};
    push       = sample && cnt_q == LAST;
    shift_d    = frame_bad ? '0 : sample ? word_next : shift_q;
    cnt_d      = (frame_bad || push) ? '0 : sample ? cnt_q + 1'b1 : cnt_q;
    pop        = m_tvalid && m_tready;
    accept     = push && (level_q != FULL || pop);
    drop       = push && !accept;
    level_d    = (accept && !pop) ? level_q + 1'b1 : (pop && !accept) ? level_q - 1'b1 : level_q;
    wr_d       = accept ? wr_q + 1'b1 : wr_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    overflow_d = (overflow_q && !clear_flags) || drop;
    frame_err_d = (frame_err_q && !clear_flags) || frame_bad;
    drop_d     = clear_flags ? {7'd0, drop} : (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  end

  // state registers; reset discards any partial word and all buffered words
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      drop_q      <= drop_d;
      if (accept) mem_q[wr_q] <= word_next;
    end
  end
endmodule

// File: doc/spi_rx_stream.md
Name: spi_rx_stream

Overview:
- Parametrised successor to the single-word SPI-style serial receiver. It oversamples a slave serial link (sclk/sdata/svalid) entirely in the aclk domain; no sclk-clocked logic.
- Assembles words of configurable width and bit order. Buffers them in an internal FIFO and presents them on an AXI-Stream master with true valid/ready backpressure.
- Adds frame-error detection, overflow detection with a drop counter, and a FIFO level output.

Parameters:
- DATA_WIDTH, 32: bits per word. Legal range 2..64.
- FIFO_DEPTH, 8: word buffer depth. Power of two, at least 2.
- MSB_FIRST, 1: 1 = first received bit lands in bit DATA_WIDTH-1; 0 = first bit lands in bit 0.
- SYNC_STAGES, 2: synchroniser flops on sclk, sdata and svalid. At least 2.

Ports:
- aclk, input, 1: sole clock.
- areset, input, 1: asynchronous, active-high reset.
- sclk, input, 1: serial clock, asynchronous to aclk. Data is sampled on its rising edge.
- sdata, input, 1: serial data.
- svalid, input, 1: frame enable, high for the whole word.
- m_tdata, output, DATA_WIDTH: stream data.
- m_tvalid, output, 1: stream valid.
- m_tready, input, 1: stream ready.
- fifo_level, output, clog2(FIFO_DEPTH+1): words currently buffered.
- overflow, output, 1: sticky; a completed word was dropped.
- frame_err, output, 1: sticky; svalid fell mid-word.
- drop_count, output, 8: saturating count of dropped words.
- clear_flags, input, 1: synchronous clear of overflow, frame_err and drop_count.

Behaviour:
- Reset: all outputs 0, FIFO empty, bit counter 0, synchronisers 0. Assertion mid-word discards the partial word and all buffered words.
- Synchronisation and edge detect:
  - sclk, sdata and svalid each pass through SYNC_STAGES flops. ss_* denotes the last stage.
  - sample = ss_sclk AND NOT ss_sclk_d AND ss_svalid, where ss_sclk_d is ss_sclk delayed one cycle.
  - Input contract: sclk high and low phases each last at least 2 aclk periods. sdata and svalid are stable 1 aclk before and after each rising sclk.
- Assembly:
  - On sample, shift ss_sdata in. MSB_FIRST=1 shifts left with new bit at [0]; MSB_FIRST=0 shifts right with new bit at [DATA_WIDTH-1]. Increment the bit counter.
  - The sample with counter = DATA_WIDTH-1 completes the word. In that same cycle the assembled word, including the new bit, is pushed and the counter returns to 0.
- Frame error: if ss_svalid is 0 while the counter is non-zero:
  - discard the partial word and zero the counter;
  - set frame_err;
  - do not push.
  - svalid low with counter 0 is idle, not an error.
- FIFO:
  - Push accepted if level < FIFO_DEPTH, or if level = FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow is set, and drop_count increments (saturating at 255).
  - Pop occurs when m_tvalid AND m_tready.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Stream output:
  - First-word fall-through. m_tvalid = (level != 0) and m_tdata = head word.
  - A word pushed into an empty FIFO appears on m_tvalid/m_tdata on the aclk edge after the push cycle.
  - m_tdata is stable while m_tvalid is high and m_tready is low.
  - Back-to-back pops deliver one word per cycle.
- Latency: rising sclk of the final bit reaches m_tvalid in SYNC_STAGES+2 aclk cycles, ±1 for sampling phase, when the FIFO is empty.
- Flags:
  - clear_flags zeroes overflow, frame_err and drop_count on the next edge.
  - A new error or drop in the same cycle as clear_flags wins: the flag is set and drop_count = 1.
- fifo_level is registered and reflects the FIFO occupancy after each edge.

Test Plan:
- Reset mid-word: shift 10 bits, assert areset 3 cycles, then send 0xA5A5_0F0F → exactly one word 0xA5A5_0F0F is output, with no stale data.
- Single word, MSB_FIRST=1, sclk = aclk/4: send 0xDEADBEEF → m_tdata = 0xDEADBEEF, m_tvalid 1 cycle-exact per the latency rule, fifo_level 1→0 on handshake.
- Bit order, MSB_FIRST=0: send bit stream 1,0,0,...,0 (32 bits) → m_tdata = 0x0000_0001.
- Backpressure and overflow, FIFO_DEPTH=8, m_tready=0: send 10 words 1..10 → level = 8, overflow = 1, drop_count = 2. Releasing m_tready yields words 1..8 in order on consecutive cycles.
- Frame error: drop svalid after 17 bits, then send 0x12345678 → frame_err = 1, only 0x12345678 is output. clear_flags → frame_err = 0.
- Full with simultaneous pop: FIFO full, m_tready pulsed in the same cycle as the last-bit push → word accepted, overflow stays 0, level stays 8.
